// File: rtl/bitvault_pkg.sv
// Shared types and constants for the BitVault multi-port register file.
package bitvault_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // Wide enough for any practical DATA_W; users take the low DATA_W bits.
  localparam int                        RST_DATA_MAX_W = 256;
  localparam logic [RST_DATA_MAX_W-1:0] RST_DATA       = {RST_DATA_MAX_W{1'b0}};

endpackage

// File: rtl/bitvault_clr_seq.sv
// Clear sequencer: sweeps every entry to zero, one per cycle, after a clr_req pulse.
module bitvault_clr_seq
  import bitvault_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state_r;
  clr_state_e        state_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_s;

  // State and sweep index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLR_IDLE;
      idx_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state logic; clr_req during a sweep is deliberately ignored
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      CLR_IDLE: begin
        if (clr_req) begin
          state_s = CLR_SWEEP;
          idx_s   = {ADDR_W{1'b0}};
        end else begin
          state_s = CLR_IDLE;
        end
      end
      CLR_SWEEP: begin
        if (idx_r == LAST_IDX) begin
          state_s = CLR_IDLE;
          idx_s   = {ADDR_W{1'b0}};
        end else begin
          idx_s = idx_r + ADDR_W'(1);
        end
      end
      default: begin
        state_s = CLR_IDLE;
        idx_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign busy     = (state_r == CLR_SWEEP);
  assign clr_we   = (state_r == CLR_SWEEP);
  assign clr_addr = idx_r;

endmodule

// File: rtl/bitvault_regfile_mp.sv
// Multi-port register file: one write port, two registered read ports with
// write-first bypass, and a hardware clear sweep that owns the write port.
module bitvault_regfile_mp
  import bitvault_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ZERO_REG0 = 0,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              clr_req,
  output logic              busy
);

  localparam logic [DATA_W-1:0] ZERO_C  = RST_DATA[DATA_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] ra_r;
  logic [DATA_W-1:0] rb_r;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] ra_next_s;
  logic [DATA_W-1:0] rb_next_s;

  // Entry is backed by storage and not the hardwired-zero slot
  function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_C) && !((ZERO_REG0 != 0) && (addr == {ADDR_W{1'b0}}));
  endfunction

  bitvault_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Write arbitration: the sweep owns the port and user writes are dropped
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = waddr;
    mem_wdata_s = wdata;
    if (clr_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_s;
      mem_wdata_s = ZERO_C;
    end else if (we && addr_live(waddr)) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ZERO_C;
      end
    end else if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read muxes with write-first bypass of whatever lands on this edge
  always_comb begin
    ra_next_s = ZERO_C;
    rb_next_s = ZERO_C;
    if (!addr_live(ra_addr)) begin
      ra_next_s = ZERO_C;
    end else if (mem_we_s && (ra_addr == mem_waddr_s)) begin
      ra_next_s = mem_wdata_s;
    end else begin
      ra_next_s = mem_r[ra_addr];
    end
    if (!addr_live(rb_addr)) begin
      rb_next_s = ZERO_C;
    end else if (mem_we_s && (rb_addr == mem_waddr_s)) begin
      rb_next_s = mem_wdata_s;
    end else begin
      rb_next_s = mem_r[rb_addr];
    end
  end

  // Read data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_r <= ZERO_C;
      rb_r <= ZERO_C;
    end else begin
      ra_r <= ra_next_s;
      rb_r <= rb_next_s;
    end
  end

  assign ra_data = ra_r;
  assign rb_data = rb_r;

endmodule

// File: tb/tb_bitvault_regfile_mp.sv
// Randomized self-checking bench for bitvault_regfile_mp (default config and a
// DEPTH=12, ZERO_REG0=1 config) against an array-based reference model.
module tb_bitvault_regfile_mp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0, clr_req = 1'b0, busy;
  logic [3:0] waddr = 4'd0, ra_addr = 4'd0, rb_addr = 4'd0;
  logic [7:0] wdata = 8'd0, ra_data, rb_data;
  logic       we2 = 1'b0, clr_req2 = 1'b0, busy2;
  logic [3:0] waddr2 = 4'd0, ra_addr2 = 4'd0, rb_addr2 = 4'd0;
  logic [7:0] wdata2 = 8'd0, ra_data2, rb_data2;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays plus a "next entry to wipe" pointer
  logic [7:0] m1 [16];
  logic [7:0] m2 [12];
  bit         sweeping;
  int         sweep_next;
  logic [7:0] exp_a, exp_b, exp_a2, exp_b2;
  logic       exp_busy;

  always #5 clk = ~clk;

  bitvault_regfile_mp dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
    .clr_req(clr_req), .busy(busy)
  );

  bitvault_regfile_mp #(.DATA_W(8), .DEPTH(12), .ZERO_REG0(1)) dut2 (
    .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .ra_addr(ra_addr2), .ra_data(ra_data2), .rb_addr(rb_addr2), .rb_data(rb_data2),
    .clr_req(clr_req2), .busy(busy2)
  );

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m1[i] = 8'h00;
    for (int i = 0; i < 12; i++) m2[i] = 8'h00;
    sweeping = 1'b0; sweep_next = 0;
    exp_a = 8'h00; exp_b = 8'h00; exp_a2 = 8'h00; exp_b2 = 8'h00; exp_busy = 1'b0;
  endtask

  function automatic logic [7:0] rd2(input logic [3:0] a);
    return (a < 4'd12 && a != 4'd0) ? m2[a] : 8'h00;
  endfunction

  // Apply one clock edge to the model with the currently driven inputs, then
  // advance the DUT and settle just after the edge.
  task automatic tick();
    if (sweeping) begin
      m1[sweep_next] = 8'h00;
      sweep_next++;
      if (sweep_next == 16) sweeping = 1'b0;
    end else begin
      if (we) m1[waddr] = wdata;
      if (clr_req) begin sweeping = 1'b1; sweep_next = 0; end
    end
    if (we2 && waddr2 < 4'd12 && waddr2 != 4'd0) m2[waddr2] = wdata2;
    exp_a = m1[ra_addr]; exp_b = m1[rb_addr];
    exp_a2 = rd2(ra_addr2); exp_b2 = rd2(rb_addr2);
    exp_busy = sweeping;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (ra_data !== 8'h00) begin errors++; $display("FAIL rst_ra got=%h exp=00", ra_data); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra_addr = 4'(i); rb_addr = 4'(15 - i);
      tick();
      checks++; if (ra_data !== 8'h00) begin errors++; $display("FAIL rst_read_a addr=%0d got=%h exp=00", i, ra_data); end
      checks++; if (rb_data !== 8'h00) begin errors++; $display("FAIL rst_read_b addr=%0d got=%h exp=00", 15 - i, rb_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    end
  endtask

  task automatic test_write_bypass();
    we = 1'b1; waddr = 4'd5; wdata = 8'hA5; ra_addr = 4'd5; rb_addr = 4'd5;
    tick();
    checks++; if (ra_data !== 8'hA5) begin errors++; $display("FAIL bypass_a got=%h exp=a5", ra_data); end
    checks++; if (rb_data !== 8'hA5) begin errors++; $display("FAIL bypass_b got=%h exp=a5", rb_data); end
    we = 1'b0;
    tick();
    checks++; if (ra_data !== 8'hA5) begin errors++; $display("FAIL hold_a got=%h exp=a5", ra_data); end
    checks++; if (rb_data !== exp_b) begin errors++; $display("FAIL hold_b got=%h exp=%h", rb_data, exp_b); end
  endtask

  task automatic test_random(input int n, input int clr_odds);
    for (int k = 0; k < n; k++) begin
      we = 1'($urandom_range(0, 1)); waddr = 4'($urandom); wdata = 8'($urandom);
      ra_addr = 4'($urandom); rb_addr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
      clr_req = (clr_odds > 0) && ($urandom_range(0, clr_odds) == 0);
      we2 = 1'($urandom_range(0, 1)); waddr2 = 4'($urandom); wdata2 = 8'($urandom);
      ra_addr2 = ($urandom_range(0, 1) == 0) ? waddr2 : 4'($urandom); rb_addr2 = 4'($urandom);
      tick();
      checks++; if (ra_data !== exp_a) begin errors++; $display("FAIL rnd_a cyc=%0d addr=%0d got=%h exp=%h", k, ra_addr, ra_data, exp_a); end
      checks++; if (rb_data !== exp_b) begin errors++; $display("FAIL rnd_b cyc=%0d addr=%0d got=%h exp=%h", k, rb_addr, rb_data, exp_b); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", k, busy, exp_busy); end
      checks++; if (ra_data2 !== exp_a2) begin errors++; $display("FAIL rnd_z_a cyc=%0d addr=%0d got=%h exp=%h", k, ra_addr2, ra_data2, exp_a2); end
      checks++; if (rb_data2 !== exp_b2) begin errors++; $display("FAIL rnd_z_b cyc=%0d addr=%0d got=%h exp=%h", k, rb_addr2, rb_data2, exp_b2); end
    end
    we = 1'b0; clr_req = 1'b0; we2 = 1'b0;
    // let any sweep started by the random traffic finish
    for (int g = 0; g < 20 && sweeping; g++) tick();
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; waddr = 4'(i); wdata = 8'h10 + 8'(i);
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_clear_sweep();
    int cnt;
    fill();
    ra_addr = 4'd15; rb_addr = 4'd3; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = (busy === 1'b1) ? 1 : 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise got=%b exp=1", busy); end
    for (int k = 1; k < 40 && busy === 1'b1; k++) begin
      we = (k == 5); waddr = 4'd3; wdata = 8'hEE;
      tick();
      if (busy === 1'b1) cnt++;
      checks++; if (ra_data !== ((k >= 16) ? 8'h00 : 8'h1F)) begin errors++; $display("FAIL clr_track15 k=%0d got=%h exp=%h", k, ra_data, (k >= 16) ? 8'h00 : 8'h1F); end
      checks++; if (rb_data !== exp_b) begin errors++; $display("FAIL clr_read3 k=%0d got=%h exp=%h", k, rb_data, exp_b); end
    end
    we = 1'b0;
    checks++; if (cnt !== 16) begin errors++; $display("FAIL clr_busy_len got=%0d exp=16", cnt); end
    ra_addr = 4'd3;
    tick();
    checks++; if (ra_data !== 8'h00) begin errors++; $display("FAIL clr_dropped_write got=%h exp=00", ra_data); end
  endtask

  task automatic test_clear_collision();
    int cnt;
    we = 1'b1; waddr = 4'd9; wdata = 8'h77; clr_req = 1'b1; rb_addr = 4'd9;
    tick();
    we = 1'b0; clr_req = 1'b0;
    checks++; if (rb_data !== 8'h77) begin errors++; $display("FAIL coll_commit got=%h exp=77", rb_data); end
    cnt = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k < 40 && busy === 1'b1; k++) begin
      clr_req = (k == 5);
      tick();
      if (busy === 1'b1) cnt++;
      checks++; if (rb_data !== ((k >= 10) ? 8'h00 : 8'h77)) begin errors++; $display("FAIL coll_e9 k=%0d got=%h exp=%h", k, rb_data, (k >= 10) ? 8'h00 : 8'h77); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL coll_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
    end
    clr_req = 1'b0;
    checks++; if (cnt !== 16) begin errors++; $display("FAIL coll_busy_len got=%0d exp=16", cnt); end
  endtask

  task automatic test_zero_reg();
    we2 = 1'b1; waddr2 = 4'd0; wdata2 = 8'hFF; ra_addr2 = 4'd0; rb_addr2 = 4'd13;
    tick();
    checks++; if (ra_data2 !== 8'h00) begin errors++; $display("FAIL z_write0 got=%h exp=00", ra_data2); end
    waddr2 = 4'd13; ra_addr2 = 4'd13; rb_addr2 = 4'd0;
    tick();
    checks++; if (ra_data2 !== 8'h00) begin errors++; $display("FAIL z_write13 got=%h exp=00", ra_data2); end
    checks++; if (rb_data2 !== 8'h00) begin errors++; $display("FAIL z_read0 got=%h exp=00", rb_data2); end
    waddr2 = 4'd11; wdata2 = 8'h5A; ra_addr2 = 4'd11;
    tick();
    we2 = 1'b0;
    checks++; if (ra_data2 !== 8'h5A) begin errors++; $display("FAIL z_write11 got=%h exp=5a", ra_data2); end
    tick();
    checks++; if (ra_data2 !== exp_a2) begin errors++; $display("FAIL z_hold11 got=%h exp=%h", ra_data2, exp_a2); end
  endtask

  task automatic test_reset_mid_sweep();
    fill();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (ra_data !== 8'h00) begin errors++; $display("FAIL mid_rst_ra got=%h exp=00", ra_data); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra_addr = 4'(i); rb_addr = 4'(i);
      tick();
      checks++; if (ra_data !== 8'h00) begin errors++; $display("FAIL mid_rst_read addr=%0d got=%h exp=00", i, ra_data); end
    end
    we = 1'b1; waddr = 4'd2; wdata = 8'h3C; ra_addr = 4'd2;
    tick();
    we = 1'b0;
    checks++; if (ra_data !== 8'h3C) begin errors++; $display("FAIL mid_rst_write got=%h exp=3c", ra_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got=%b exp=0", busy); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_bypass();
    test_random(200, 0);
    test_clear_sweep();
    test_clear_collision();
    test_zero_reg();
    test_random(400, 25);
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
